eclk_stop_ctrl: RTL and testbench



---
 rtl/eclk_stop_ctrl_pkg.sv | 25 ++
 rtl/eclk_stop_ctrl_seq.sv | 28 ++
 rtl/eclk_stop_ctrl.sv | 121 ++++++++++++
 tb/tb_eclk_stop_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/eclk_stop_ctrl_pkg.sv
// Shared types and default timing for the edge-clock stop/divider-reset sequencer.
// ECLK_STOP_CTRL_DLL_UPD_EN adds the DLL freeze/update states to the state enum.
package eclk_stop_ctrl_pkg;

  localparam int unsigned CW          = 8;
  localparam int unsigned T_STOP_DEF  = 8;
  localparam int unsigned T_DIV_DEF   = 4;
  localparam int unsigned T_UPD_DEF   = 4;
  localparam int unsigned T_START_DEF = 8;

  typedef enum logic [3:0] {
    S_WAIT_LOCK,
    S_HALT,
    S_DIV_RST,
    S_DIV_REL,
`ifdef ECLK_STOP_CTRL_DLL_UPD_EN
    S_FRZ,
    S_UPD,
    S_UNFRZ,
`endif
    S_START,
    S_READY
  } state_t;

endpackage

// File: rtl/eclk_stop_ctrl_seq.sv
// seq_timer: loadable down-counter shared by all timed sequencer states.
// Holds at zero; clr aborts a running interval.
module seq_timer #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/eclk_stop_ctrl.sv
// Sequencer for ECLK STOP and divider reset so ECLK/SCLK stay phase-aligned.
// Define ECLK_STOP_CTRL_DLL_UPD_EN to include the DLL freeze/update phase.
module eclk_stop_ctrl #(
  parameter int unsigned T_STOP  = eclk_stop_ctrl_pkg::T_STOP_DEF,
  parameter int unsigned T_DIV   = eclk_stop_ctrl_pkg::T_DIV_DEF,
  parameter int unsigned T_UPD   = eclk_stop_ctrl_pkg::T_UPD_DEF,
  parameter int unsigned T_START = eclk_stop_ctrl_pkg::T_START_DEF,
  parameter int unsigned CW      = eclk_stop_ctrl_pkg::CW
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock,
  input  logic req,
  output logic stop,
  output logic div_rst,
  output logic freeze,
  output logic uddcntln,
  output logic busy,
  output logic ready,
  output logic done
);
  import eclk_stop_ctrl_pkg::*;

  state_t        state;
  state_t        nxt;
  logic          tmr_load;
  logic          tmr_clr;
  logic          tmr_zero;
  logic [CW-1:0] tmr_val;

  seq_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Timer is loaded with T-1 on the entering edge, so a state exits after exactly T cycles.
  always_comb begin
    nxt      = state;
    tmr_load = 1'b0;
    tmr_clr  = 1'b0;
    tmr_val  = '0;
    if (state != S_WAIT_LOCK && !pll_lock) begin
      nxt     = S_WAIT_LOCK;
      tmr_clr = 1'b1;
    end else begin
      case (state)
        S_WAIT_LOCK: if (pll_lock) begin
          nxt = S_DIV_RST; tmr_load = 1'b1; tmr_val = CW'(T_DIV - 1);
        end
        S_HALT: if (tmr_zero) begin
          nxt = S_DIV_RST; tmr_load = 1'b1; tmr_val = CW'(T_DIV - 1);
        end
        S_DIV_RST: if (tmr_zero) begin
          nxt = S_DIV_REL; tmr_load = 1'b1; tmr_val = CW'(T_DIV - 1);
        end
`ifdef ECLK_STOP_CTRL_DLL_UPD_EN
        S_DIV_REL: if (tmr_zero) begin
          nxt = S_FRZ; tmr_load = 1'b1; tmr_val = CW'(T_UPD - 1);
        end
        S_FRZ: if (tmr_zero) begin
          nxt = S_UPD; tmr_load = 1'b1; tmr_val = CW'(T_UPD - 1);
        end
        S_UPD: if (tmr_zero) begin
          nxt = S_UNFRZ; tmr_load = 1'b1; tmr_val = CW'(T_UPD - 1);
        end
        S_UNFRZ: if (tmr_zero) begin
          nxt = S_START; tmr_load = 1'b1; tmr_val = CW'(T_START - 1);
        end
`else
        S_DIV_REL: if (tmr_zero) begin
          nxt = S_START; tmr_load = 1'b1; tmr_val = CW'(T_START - 1);
        end
`endif
        S_START: if (tmr_zero) nxt = S_READY;
        S_READY: if (req) begin
          nxt = S_HALT; tmr_load = 1'b1; tmr_val = CW'(T_STOP - 1);
        end
        default: nxt = S_WAIT_LOCK;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_WAIT_LOCK;
      stop    <= 1'b1;
      div_rst <= 1'b1;
      busy    <= 1'b1;
      ready   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt;
      stop    <= (nxt != S_START) && (nxt != S_READY);
      div_rst <= (nxt == S_WAIT_LOCK) || (nxt == S_DIV_RST);
      busy    <= (nxt != S_READY);
      ready   <= (nxt == S_READY);
      done    <= (nxt == S_READY) && (state != S_READY);
    end
  end

`ifdef ECLK_STOP_CTRL_DLL_UPD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      freeze   <= 1'b0;
      uddcntln <= 1'b1;
    end else begin
      freeze   <= (nxt == S_FRZ) || (nxt == S_UPD);
      uddcntln <= (nxt != S_UPD);
    end
  end
`else
  assign freeze   = 1'b0;
  assign uddcntln = 1'b1;
`endif

endmodule

// File: tb/tb_eclk_stop_ctrl.sv
// Scoreboard bench for eclk_stop_ctrl: stimulus queues per-cycle expected outputs,
// a monitor pops and compares them; honours ECLK_STOP_CTRL_DLL_UPD_EN.
module tb_eclk_stop_ctrl;

  logic clk = 1'b0;
  logic rst, pll_lock, req;
  logic stop, div_rst, freeze, uddcntln, busy, ready, done;

  always #5 clk = ~clk;

  eclk_stop_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .pll_lock (pll_lock),
    .req      (req),
    .stop     (stop),
    .div_rst  (div_rst),
    .freeze   (freeze),
    .uddcntln (uddcntln),
    .busy     (busy),
    .ready    (ready),
    .done     (done)
  );

  // {stop, div_rst, freeze, uddcntln, busy, ready, done}
  localparam logic [6:0] V_WL   = 7'b1101100;
  localparam logic [6:0] V_HLT  = 7'b1001100;
  localparam logic [6:0] V_DR   = 7'b1101100;
  localparam logic [6:0] V_DREL = 7'b1001100;
  localparam logic [6:0] V_FRZ  = 7'b1011100;
  localparam logic [6:0] V_UPD  = 7'b1010100;
  localparam logic [6:0] V_UNF  = 7'b1001100;
  localparam logic [6:0] V_ST   = 7'b0001100;
  localparam logic [6:0] V_RDY1 = 7'b0001011;
  localparam logic [6:0] V_RDY  = 7'b0001010;

  typedef struct {
    int         cyc;
    logic [6:0] v;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   ecyc   = 1;
  int   errors = 0;
  int   checks = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp_run(input logic [6:0] v, input int n, input string nm);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc = ecyc; e.v = v; e.nm = nm;
      q.push_back(e);
      ecyc++;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic dll_phase(input string nm);
`ifdef ECLK_STOP_CTRL_DLL_UPD_EN
    exp_run(V_FRZ, 4, {nm, "_frz"});
    exp_run(V_UPD, 4, {nm, "_upd"});
    exp_run(V_UNF, 4, {nm, "_unfrz"});
`else
    if (nm.len() < 0) exp_run(V_UNF, 0, nm);
`endif
  endtask

  // Lock-sampled edge is the first DIV_RST cycle; READY follows 16 (28 with DLL) cycles later.
  task automatic lock_seq(input string nm, input int n_rdy);
    exp_run(V_DR,   4, {nm, "_divrst"});
    exp_run(V_DREL, 4, {nm, "_divrel"});
    dll_phase(nm);
    exp_run(V_ST,   8, {nm, "_start"});
    exp_run(V_RDY1, 1, {nm, "_done"});
    exp_run(V_RDY,  n_rdy, {nm, "_ready"});
  endtask

  // Monitor: invariants every cycle, plus the queued expectation due this cycle.
  initial begin
    exp_t e;
    logic [6:0] obs;
    forever begin
      @(negedge clk);
      #1;
      obs = {stop, div_rst, freeze, uddcntln, busy, ready, done};
      checks++;
      if (div_rst && !stop) begin
        errors++;
        $display("FAIL inv_divrst_stop cyc=%0d div_rst=%b stop=%b (required stop=1)", cyc, div_rst, stop);
      end
      checks++;
      if (done && done_prev) begin
        errors++;
        $display("FAIL inv_done_pulse cyc=%0d done high two cycles (required single pulse)", cyc);
      end
      done_prev = done;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc || obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%b required=%b", e.nm, e.cyc, obs, e.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d queue=%0d (required run to complete)", cyc, q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    rst = 1'b1; pll_lock = 1'b0; req = 1'b0;

    // Reset, then lock sampled at edge 3.
    exp_run(V_WL, 2, "reset");
    wait_cyc(1); rst = 1'b0;
    wait_cyc(2); pll_lock = 1'b1;
    lock_seq("lock", 3);

    // One-cycle req: ready falls, HALT lasts 8, ready back 24 cycles after the sample.
    wait_cyc(ecyc - 1); req = 1'b1; h = ecyc;
    exp_run(V_HLT, 8, "req_halt");
    lock_seq("req", 2);
    wait_cyc(h); req = 1'b0;

    // Held req: READY lasts exactly one cycle before the next HALT.
    wait_cyc(ecyc - 1); req = 1'b1;
    exp_run(V_HLT, 8, "held_halt");
    lock_seq("held", 0);
    h = ecyc;
    exp_run(V_HLT, 8, "held_halt2");
    lock_seq("held2", 2);
    wait_cyc(h); req = 1'b0;

    // Lock loss during START, then relock.
    wait_cyc(ecyc - 1); req = 1'b1; h = ecyc;
    exp_run(V_HLT, 8, "ll_halt");
    exp_run(V_DR, 4, "ll_divrst");
    exp_run(V_DREL, 4, "ll_divrel");
    dll_phase("ll");
    exp_run(V_ST, 3, "ll_start");
    wait_cyc(h); req = 1'b0;
    wait_cyc(ecyc - 1); pll_lock = 1'b0;
    exp_run(V_WL, 2, "lockloss");
    wait_cyc(ecyc - 1); pll_lock = 1'b1;
    lock_seq("relock", 2);

    // Synchronous reset in DIV_REL.
    wait_cyc(ecyc - 1); req = 1'b1; h = ecyc;
    exp_run(V_HLT, 8, "rm_halt");
    exp_run(V_DR, 4, "rm_divrst");
    exp_run(V_DREL, 2, "rm_divrel");
    wait_cyc(h); req = 1'b0;
    wait_cyc(ecyc - 1); rst = 1'b1;
    exp_run(V_WL, 1, "rst_mid");
    wait_cyc(ecyc - 1); rst = 1'b0;
    lock_seq("post_rst", 2);

    wait_cyc(ecyc);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
